// File: rtl/negacyclic_pkg.sv
// Shared types and modular helpers for the negacyclic binary/ternary MAC.
// Optional feature macro: TERNARY_EN (2-bit signed r coefficients).
package negacyclic_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_N     = 8;
    localparam int DEF_QW    = 12;
    localparam int DEF_Q     = 3329;
    localparam int DEF_LOG2N = $clog2(DEF_N);

    // Ternary r encoding, 2 bits per coefficient
    localparam logic [1:0] TRN_ZERO = 2'b00;
    localparam logic [1:0] TRN_POS  = 2'b01;
    localparam logic [1:0] TRN_RSV  = 2'b10;
    localparam logic [1:0] TRN_NEG  = 2'b11;

    // (a + b) mod q for a, b < q; callers cast to their coefficient width
    function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q})
            s = s - {1'b0, q};
        return s[31:0];
    endfunction

    // (-x) mod q for x < q
    function automatic logic [31:0] mod_neg(input logic [31:0] x, input logic [31:0] q);
        return (x == 32'd0) ? 32'd0 : (q - x);
    endfunction

endpackage

// File: rtl/modq_add_tree.sv
// Pipelined mod-Q adder tree: N leaves reduced over log2(N) registered levels.
// Nodes use heap numbering: node n sums nodes 2n and 2n+1; leaves are nodes N..2N-1.
module modq_add_tree
    import negacyclic_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int QW = DEF_QW,
    parameter int Q  = DEF_Q
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_vld,
    input  logic [N*QW-1:0] i_leaf,
    output logic            o_vld,
    output logic [QW-1:0]   o_sum
);
    localparam int LOG2N = $clog2(N);

    logic [QW-1:0]    r_node [1:N-1];
    logic [LOG2N-1:0] r_vld;
    logic [QW-1:0]    w_all  [2*N];

    // Flatten internal nodes and leaves into one heap-indexed view
    always_comb begin
        w_all[0] = '0;
        for (int n = 1; n < N; n++)
            w_all[n] = r_node[n];
        for (int j = 0; j < N; j++)
            w_all[N + j] = i_leaf[j*QW +: QW];
    end

    // One mod-Q add per node per cycle; valid marches alongside the levels
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 1; n < N; n++)
                r_node[n] <= '0;
            r_vld <= '0;
        end else begin
            for (int n = 1; n < N; n++)
                r_node[n] <= QW'(mod_add(32'(w_all[2*n]), 32'(w_all[2*n+1]), 32'(Q)));
            r_vld[0] <= i_vld;
            for (int i = 1; i < LOG2N; i++)
                r_vld[i] <= r_vld[i-1];
        end
    end

    assign o_vld = r_vld[LOG2N-1];
    assign o_sum = r_node[1];

endmodule

// File: rtl/negacyclic_bin_mac.sv
// out = c1*r + c2 in Z_Q[x]/(x^N+1), r binary (or ternary with TERNARY_EN defined).
// A rotating register walks c1*x^k; each cycle one coefficient enters the adder tree.
module negacyclic_bin_mac
    import negacyclic_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int QW = DEF_QW,
    parameter int Q  = DEF_Q
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*QW-1:0] c1_in,
    input  logic [N*QW-1:0] c2_in,
`ifdef TERNARY_EN
    input  logic [2*N-1:0]  r_in,
`else
    input  logic [N-1:0]    r_in,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*QW-1:0] out_data,
    output logic            busy
);
    localparam int LOG2N = $clog2(N);
    localparam int CW    = LOG2N + 1;
`ifdef TERNARY_EN
    localparam int RW = 2 * N;
`else
    localparam int RW = N;
`endif

    state_t           r_state;
    logic [QW-1:0]    r_a [N];
    logic [N*QW-1:0]  r_c2;
    logic [RW-1:0]    r_r;
    logic [CW-1:0]    r_iss_cnt;
    logic [LOG2N-1:0] r_wr_idx;
    logic [N*QW-1:0]  r_out_data;
    logic             r_out_valid;

    logic             w_issue;
    logic [N*QW-1:0]  w_leaf;
    logic             w_sum_vld;
    logic [QW-1:0]    w_sum;
    logic [QW-1:0]    w_c2_k;

    assign w_issue   = (r_state == RUN) && (r_iss_cnt != CW'(N));
    assign w_c2_k    = r_c2[r_wr_idx*QW +: QW];
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Leaf selection: r picks (or negates) the current rotated c1 coefficients
    always_comb begin
        w_leaf = '0;
        for (int j = 0; j < N; j++) begin
`ifdef TERNARY_EN
            case (r_r[2*j +: 2])
                TRN_POS:  w_leaf[j*QW +: QW] = r_a[j];
                TRN_NEG:  w_leaf[j*QW +: QW] = QW'(mod_neg(32'(r_a[j]), 32'(Q)));
                TRN_ZERO: w_leaf[j*QW +: QW] = '0;
                TRN_RSV:  w_leaf[j*QW +: QW] = '0;
                default:  w_leaf[j*QW +: QW] = '0;
            endcase
`else
            if (r_r[j])
                w_leaf[j*QW +: QW] = r_a[j];
`endif
        end
    end

    modq_add_tree #(
        .N  (N),
        .QW (QW),
        .Q  (Q)
    ) u_tree (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_vld   (w_issue),
        .i_leaf  (w_leaf),
        .o_vld   (w_sum_vld),
        .o_sum   (w_sum)
    );

    // FSM, operand capture, negacyclic rotation, +c2 stage and result buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            for (int j = 0; j < N; j++)
                r_a[j] <= '0;
            r_c2        <= '0;
            r_r         <= '0;
            r_iss_cnt   <= '0;
            r_wr_idx    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // a_0 holds c1 already rotated by one negacyclic step per index
                        for (int j = 0; j < N; j++)
                            r_a[j] <= (j == 0) ? c1_in[0 +: QW]
                                      : QW'(mod_neg(32'(c1_in[((N-j)%N)*QW +: QW]), 32'(Q)));
                        r_c2      <= c2_in;
                        r_r       <= r_in;
                        r_iss_cnt <= '0;
                        r_wr_idx  <= '0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        for (int j = 1; j < N; j++)
                            r_a[j] <= r_a[j-1];
                        r_a[0]    <= QW'(mod_neg(32'(r_a[N-1]), 32'(Q)));
                        r_iss_cnt <= r_iss_cnt + CW'(1);
                    end
                    if (w_sum_vld) begin
                        r_out_data[r_wr_idx*QW +: QW] <=
                            QW'(mod_add(32'(w_sum), 32'(w_c2_k), 32'(Q)));
                        r_wr_idx <= r_wr_idx + 1'b1;
                        if (r_wr_idx == LOG2N'(N-1)) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_negacyclic_bin_mac.sv
// Directed bench for negacyclic_bin_mac at N=4, QW=5, Q=17.
// Honours TERNARY_EN: binary vectors are re-encoded and the -1 case is added.
module tb_negacyclic_bin_mac;
    localparam int N  = 4;
    localparam int QW = 5;
    localparam int Q  = 17;
    localparam int DW = N * QW;
`ifdef TERNARY_EN
    localparam int RW = 2 * N;
`else
    localparam int RW = N;
`endif

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] c1_in;
    logic [DW-1:0] c2_in;
    logic [RW-1:0] r_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    int n_chk;
    int n_fail;

    negacyclic_bin_mac #(.N(N), .QW(QW), .Q(Q)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c1_in     (c1_in),
        .c2_in     (c2_in),
        .r_in      (r_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operands presented on an accepting edge must be reduced mod Q
    always @(posedge clk) begin
        if (reset_n && in_valid && in_ready) begin
            for (int k = 0; k < N; k++) begin
                assert (c1_in[k*QW +: QW] < Q && c2_in[k*QW +: QW] < Q)
                    else $error("operand coefficient %0d out of range", k);
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {QW'(a3), QW'(a2), QW'(a1), QW'(a0)};
    endfunction

    // Binary r pattern (bit k = coeff of x^k) in the build's r encoding
    function automatic logic [RW-1:0] rb(input logic [3:0] b);
        logic [RW-1:0] v;
        v = '0;
`ifdef TERNARY_EN
        for (int i = 0; i < N; i++)
            v[2*i +: 2] = b[i] ? 2'b01 : 2'b00;
`else
        v = b;
`endif
        return v;
    endfunction

    // Full operation: accept, check latency and result, optional backpressure, handshake
    task automatic run_op(input string tag, input logic [DW-1:0] c1, input logic [DW-1:0] c2,
                          input logic [RW-1:0] r, input logic [DW-1:0] exp, input int hold);
        int lat;
        @(negedge clk);
        c1_in = c1; c2_in = c2; r_in = r; in_valid = 1'b1; out_ready = 1'b0;
        chk_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        c1_in = pk(16, 16, 16, 16); c2_in = '0; r_in = '1;
        chk_eq({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_eq({tag, "_latency"}, 64'(lat), 64'd6);
        chk_eq({tag, "_data"}, 64'(out_data), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk_eq({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            chk_eq({tag, "_hold_data"}, 64'(out_data), 64'(exp));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_eq({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        chk_eq({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        chk_eq({tag, "_post_busy"}, 64'(busy), 64'd0);
        chk_eq({tag, "_post_data"}, 64'(out_data), 64'(exp));
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        c1_in = '0; c2_in = '0; r_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
        chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // c1 * 1
        run_op("t1_identity", pk(1, 2, 3, 4), '0, rb(4'b0001), pk(1, 2, 3, 4), 0);
        // c1 * x : top coefficient wraps negated
        run_op("t2_shift1", pk(1, 2, 3, 4), '0, rb(4'b0010), pk(13, 1, 2, 3), 0);
        // sum of 1 plus 16 reaches Q exactly
        run_op("t3_wrapq", pk(1, 0, 0, 0), pk(16, 16, 16, 16), rb(4'b1111), pk(0, 0, 0, 0), 0);
        // c1 * (1 + x) + 1
        run_op("tx_two_terms", pk(1, 2, 3, 4), pk(1, 1, 1, 1), rb(4'b0011), pk(15, 4, 6, 8), 0);
        // c1 * x^3
        run_op("tx_shift3", pk(1, 2, 3, 4), '0, rb(4'b1000), pk(15, 14, 13, 1), 0);
        // backpressure for 20 cycles with a competing request
        run_op("t4_backpressure", pk(1, 2, 3, 4), '0, rb(4'b0001), pk(1, 2, 3, 4), 20);

        // reset two cycles into an operation
        @(negedge clk);
        c1_in = pk(1, 2, 3, 4); c2_in = '0; r_in = rb(4'b0001); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk_eq("t5_rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("t5_rst_out_data", 64'(out_data), 64'd0);
        chk_eq("t5_rst_in_ready", 64'(in_ready), 64'd1);
        chk_eq("t5_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_eq("t5_release_in_ready", 64'(in_ready), 64'd1);
        chk_eq("t5_release_out_valid", 64'(out_valid), 64'd0);
        run_op("t5_after_reset", pk(1, 2, 3, 4), '0, rb(4'b0001), pk(1, 2, 3, 4), 0);

`ifdef TERNARY_EN
        // -1 on coefficient 0, reserved code on coefficient 1 contributes nothing
        run_op("t6_ternary_neg", pk(1, 2, 3, 4), '0, 8'b0000_1011, pk(16, 15, 14, 13), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
